// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider.
// Holds operation encodings, FSM state encoding and the special-case result constants.
// Helper functions decode the op field so the datapath reads in RISC-V terms.
package div_pkg;

    localparam int unsigned DEF_XLEN = 32;

    // Operation select, identical to funct3[1:0] of DIV/DIVU/REM/REMU.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Quotient returned for a zero divisor.
    localparam logic [DEF_XLEN-1:0] DIV0_QUOTIENT = '1;
    // Most negative dividend; divided by -1 it overflows in signed arithmetic.
    localparam logic [DEF_XLEN-1:0] OVF_DIVIDEND  = {1'b1, {(DEF_XLEN-1){1'b0}}};

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit in and try the subtract.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: rem_i/quo_i current partial remainder and quotient/dividend shift register,
//        dvs_i divisor magnitude, rem_o/quo_o values after this iteration.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          trial_neg;

    // The full remainder is shifted, not just its low bits: with a divisor
    // above 2^(XLEN-1) the remainder's top bit can be set. Because
    // rem < divisor, the XLEN+1-bit difference never wraps, so its top bit
    // is a reliable sign.
    assign shifted   = {rem_i, quo_i[XLEN-1]};
    assign trial     = shifted - {1'b0, dvs_i};
    assign trial_neg = trial[XLEN];

    always_comb begin
        rem_o = trial_neg ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_o = {quo_i[XLEN-2:0], ~trial_neg};
    end

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Latency: out_valid in the 34th cycle after accept (XLEN+2); divide-by-zero/overflow in the 1st.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE without flush.
// Ports: in_valid/in_ready with dividend, divisor, op accept an operation;
//        out_valid/out_ready with result return it; flush aborts; busy is high outside IDLE.
module iter_divider
    import div_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [1:0]      op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;      // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Accept-time decode of the raw operands.
    logic            in_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            sgn_overflow;
    logic [XLEN-1:0] special_res;
    logic            accept;

    // Iteration and sign-fix values.
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready;

    assign in_signed = op_is_signed(op);
    assign a_neg     = in_signed && dividend[XLEN-1];
    assign b_neg     = in_signed && divisor[XLEN-1];
    // The most negative value negates to itself, which is the correct
    // unsigned magnitude.
    assign a_mag     = a_neg ? ('0 - dividend) : dividend;
    assign b_mag     = b_neg ? ('0 - divisor)  : divisor;

    assign div_by_zero  = (divisor == '0);
    assign sgn_overflow = in_signed && (dividend == OVF_DIVIDEND) && (divisor == '1);

    always_comb begin
        if (div_by_zero) begin
            special_res = op_is_rem(op) ? dividend : DIV0_QUOTIENT;
        end else begin
            special_res = op_is_rem(op) ? '0 : OVF_DIVIDEND;
        end
    end

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign quo_fixed = neg_quo_q ? ('0 - quo_q) : quo_q;
    assign rem_fixed = neg_rem_q ? ('0 - rem_q) : rem_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = div_op_e'(op);
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    cnt_d     = '0;
                    if (div_by_zero || sgn_overflow) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                result_d = op_is_rem(op_q) ? rem_fixed : quo_fixed;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over both accept (blocked via in_ready) and the output handshake.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

endmodule
